// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS core: FSM states, ALU operations,
// opcode/funct constants and the instruction-class decoder.
package mips_mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  typedef enum logic [3:0] {
    CL_ALU_R, CL_ALU_I, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_JR, CL_ILLEGAL
  } instr_class_e;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0c, OP_ORI = 6'h0d;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25, FN_SLT = 6'h2a;

  function automatic instr_class_e decode_class(input logic [5:0] op, input logic [5:0] fn);
    instr_class_e cl;
    cl = CL_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        if (fn == FN_JR) cl = CL_JR;
        else if (fn == FN_ADD || fn == FN_SUB || fn == FN_AND || fn == FN_OR || fn == FN_SLT)
          cl = CL_ALU_R;
      end
      OP_ADDI, OP_ANDI, OP_ORI: cl = CL_ALU_I;
      OP_LW:  cl = CL_LW;
      OP_SW:  cl = CL_SW;
      OP_BEQ: cl = CL_BEQ;
      OP_BNE: cl = CL_BNE;
      OP_J:   cl = CL_J;
      OP_JAL: cl = CL_JAL;
      default: cl = CL_ILLEGAL;
    endcase
    return cl;
  endfunction

  function automatic alu_op_e decode_alu(input logic [5:0] op, input logic [5:0] fn);
    alu_op_e a;
    a = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_SUB:  a = ALU_SUB;
          FN_AND:  a = ALU_AND;
          FN_OR:   a = ALU_OR;
          FN_SLT:  a = ALU_SLT;
          default: a = ALU_ADD;
        endcase
      end
      OP_BEQ, OP_BNE: a = ALU_SUB;
      OP_ANDI: a = ALU_AND;
      OP_ORI:  a = ALU_OR;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/mips_mc_fsm.sv
// Control FSM of the multicycle core: sequencing, memory handshake control,
// retire pulse and the memory-wait watchdog.
module mips_mc_fsm
  import mips_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  instr_class_e cls,
  input  logic         exec_fault,
  input  logic         mem_ready,
  output state_e       state,
  output logic         mem_req,
  output logic         mem_we,
  output logic         instr_done,
  output logic         fault
);

  state_e           nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // Gated by reset so an in-flight request is dropped the moment reset rises.
  assign mem_req = !reset && (state == ST_FETCH || state == ST_MEM);
  assign mem_we  = mem_req && (state == ST_MEM) && (cls == CL_SW);
  assign fault   = (state == ST_FAULT);
  assign tmo_hit = (MEM_TIMEOUT != 0) && mem_req && !mem_ready &&
                   (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    nxt        = state;
    instr_done = 1'b0;
    case (state)
      ST_FETCH:  if (mem_ready) nxt = ST_DECODE;
      ST_DECODE: nxt = (cls == CL_ILLEGAL) ? ST_FAULT : ST_EXEC;
      ST_EXEC: begin
        if (exec_fault) nxt = ST_FAULT;
        else begin
          case (cls)
            CL_LW, CL_SW:       nxt = ST_MEM;
            CL_ALU_R, CL_ALU_I: nxt = ST_WB;
            default: begin
              nxt        = ST_FETCH;
              instr_done = 1'b1;
            end
          endcase
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (cls == CL_LW) nxt = ST_WB;
          else begin
            nxt        = ST_FETCH;
            instr_done = 1'b1;
          end
        end
      end
      ST_WB: begin
        nxt        = ST_FETCH;
        instr_done = 1'b1;
      end
      default: nxt = ST_FAULT;
    endcase
    if (tmo_hit) nxt = ST_FAULT;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_FETCH;
      tmo_cnt <= '0;
    end else begin
      state <= nxt;
      if (nxt != state) tmo_cnt <= '0;
      else if (mem_req && !mem_ready) tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

endmodule

// File: rtl/mips_multiciclo.sv
// Multicycle MIPS core: unified req/ready memory port, inline datapath
// (register file, ALU, IR/MDR/ALU registers) driven by mips_mc_fsm.
module mips_multiciclo
  import mips_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 16,
  parameter int          TMO_W       = 5
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic [31:0] ALUresult_out,
  output logic [2:0]  state_out,
  output logic        instr_done,
  output logic        fault
);

  logic [31:0]        pc_q, ir_q, alu_q, mdr_q;
  logic [31:0]        gpr [32];
  state_e             state;
  instr_class_e       cls;
  alu_op_e            aop;
  logic [5:0]         op, fn;
  logic [4:0]         rs, rt, rd, wb_dst;
  logic [15:0]        imm;
  logic signed [31:0] rs_val, rt_val, imm_sx, alu_b, alu_out;
  logic [31:0]        jump_tgt;
  logic               exec_fault, branch_taken;

  function automatic logic signed [31:0] alu_f(input alu_op_e f, input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    logic signed [31:0] r;
    case (f)
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = (a < b) ? 32'sd1 : 32'sd0;
      default: r = a + b;
    endcase
    return r;
  endfunction

  assign op     = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign fn     = ir_q[5:0];
  assign imm    = ir_q[15:0];
  assign cls    = decode_class(op, fn);
  assign aop    = decode_alu(op, fn);
  // gpr[0] is never written, so it reads back as zero without a special case.
  assign rs_val = gpr[rs];
  assign rt_val = gpr[rt];
  assign imm_sx = {{16{imm[15]}}, imm};

  assign alu_b = (cls == CL_ALU_R || cls == CL_BEQ || cls == CL_BNE) ? rt_val :
                 (op == OP_ANDI || op == OP_ORI) ? $signed({16'h0000, imm}) : imm_sx;
  assign alu_out      = alu_f(aop, rs_val, alu_b);
  assign branch_taken = (cls == CL_BEQ && alu_out == 32'sd0) || (cls == CL_BNE && alu_out != 32'sd0);
  assign jump_tgt     = {pc_q[31:28], ir_q[25:0], 2'b00};
  assign exec_fault   = ((cls == CL_LW || cls == CL_SW) && alu_out[1:0] != 2'b00) ||
                        (cls == CL_JR && rs_val[1:0] != 2'b00);
  assign wb_dst       = (cls == CL_ALU_R) ? rd : rt;

  mips_mc_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMO_W(TMO_W)) u_fsm (
    .clock      (clock),
    .reset      (reset),
    .cls        (cls),
    .exec_fault (exec_fault),
    .mem_ready  (mem_ready),
    .state      (state),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .instr_done (instr_done),
    .fault      (fault)
  );

  assign mem_addr        = (state == ST_MEM) ? alu_q : pc_q;
  assign mem_wdata       = rt_val;
  assign pc_out          = pc_q;
  assign instruction_out = ir_q;
  assign ALUresult_out   = alu_q;
  assign state_out       = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (mem_ready) begin
            ir_q <= mem_rdata;
            pc_q <= pc_q + 32'd4;
          end
        end
        // pc already holds pc+4 here, which is the base for branches and jal's link.
        ST_EXEC: begin
          alu_q <= alu_out;
          if (!exec_fault) begin
            case (cls)
              CL_BEQ, CL_BNE: if (branch_taken) pc_q <= pc_q + {imm_sx[29:0], 2'b00};
              CL_J:  pc_q <= jump_tgt;
              CL_JAL: begin
                pc_q    <= jump_tgt;
                gpr[31] <= pc_q;
              end
              CL_JR: pc_q <= rs_val;
              default: ;
            endcase
          end
        end
        ST_MEM: if (mem_ready && cls == CL_LW) mdr_q <= mem_rdata;
        ST_WB:  if (wb_dst != 5'd0) gpr[wb_dst] <= (cls == CL_LW) ? mdr_q : alu_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multiciclo.sv
// Bench for mips_multiciclo: wait-state memory slave, directed scenarios and a
// randomized program checked against an instruction-level reference interpreter.
module tb_mips_multiciclo;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req, mem_we, mem_ready, instr_done, fault;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, instruction_out, ALUresult_out;
  logic [2:0]  state_out;

  always #5 clock = ~clock;

  mips_multiciclo dut (
    .clock           (clock),
    .reset           (reset),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ready       (mem_ready),
    .mem_rdata       (mem_rdata),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .ALUresult_out   (ALUresult_out),
    .state_out       (state_out),
    .instr_done      (instr_done),
    .fault           (fault)
  );

  // Memory slave: 1 KB, configurable wait states, optional hang.
  logic [31:0] mem [256];
  logic [31:0] img [256];
  logic        load_en = 1'b0;
  int          wcnt = 0, cur_wait = 0, fixed_wait = 0, wr_count = 0;
  bit          rand_mode = 1'b0, hang = 1'b0;
  logic [31:0] wr_addr = '0, wr_data = '0;

  assign mem_ready = mem_req && !hang && (wcnt >= (rand_mode ? cur_wait : fixed_wait));
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clock) begin
    if (load_en) mem <= img;
    else if (mem_req && mem_ready && mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      wr_addr  <= mem_addr;
      wr_data  <= mem_wdata;
      wr_count <= wr_count + 1;
    end
    if (mem_req && mem_ready) begin
      wcnt     <= 0;
      cur_wait <= int'($urandom_range(0, 2));
    end else if (mem_req) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int fn, input int rs, input int rt, input int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(input int op, input int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 32'h0;
  endtask

  // Reset the core, check its reset state, load the memory image, release.
  task automatic start_session();
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_pc", pc_out, 32'h0);
    check("rst_ir", instruction_out, 32'h0);
    check("rst_alu", ALUresult_out, 32'h0);
    check("rst_state", {29'b0, state_out}, 32'd0);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    check("rst_done", {31'b0, instr_done}, 32'd0);
    load_en = 1'b1;
    @(posedge clock);
    #1 load_en = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!instr_done && n < 200);
    check("retire_seen", {31'b0, instr_done}, 32'd1);
  endtask

  task automatic after_edge();
    @(posedge clock);
    #1;
  endtask

  // Reference interpreter state.
  logic [31:0] mreg [32];
  logic [31:0] mmem [256];
  logic [31:0] mpc;

  task automatic model_step(output logic [31:0] ins, output logic [31:0] ea, output bit av);
    logic [31:0] a, b, sx, zx;
    logic [4:0]  rs, rt, rd;
    ins = mmem[mpc[9:2]];
    mpc = mpc + 32'd4;
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    a  = mreg[rs];   b  = mreg[rt];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0, ins[15:0]};
    av = 1'b1;
    ea = 32'h0;
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20: ea = a + b;
          6'h22: ea = a - b;
          6'h24: ea = a & b;
          6'h25: ea = a | b;
          default: ea = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
        mreg[rd] = ea;
      end
      6'h08: begin ea = a + sx; mreg[rt] = ea; end
      6'h0c: begin ea = a & zx; mreg[rt] = ea; end
      6'h0d: begin ea = a | zx; mreg[rt] = ea; end
      6'h23: begin ea = a + sx; mreg[rt] = mmem[ea[9:2]]; end
      6'h2b: begin ea = a + sx; mmem[ea[9:2]] = b; end
      6'h04: begin av = 1'b0; if (a == b) mpc = mpc + (sx << 2); end
      default: begin av = 1'b0; if (a != b) mpc = mpc + (sx << 2); end
    endcase
    mreg[0] = 32'h0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  int n, req_cnt, wc0;
  int fn_tab[5] = '{32, 34, 36, 37, 42};
  int iop_tab[3] = '{8, 12, 13};
  logic [31:0] exp_pc [5] = '{32'h20, 32'h40, 32'h24, 32'h10, 32'h10};
  logic [31:0] e_ins, e_alu;
  bit e_av;

  initial begin
    // Arithmetic, then store/load with two wait states per access.
    clear_img();
    img[0] = enc_i(8, 0, 1, 5);
    img[1] = enc_i(8, 0, 2, -3);
    img[2] = enc_r(32, 1, 2, 3);
    img[3] = enc_i(8'h2b, 0, 3, 8);
    img[4] = enc_i(8'h23, 0, 4, 8);
    img[5] = enc_r(32, 4, 0, 5);
    fixed_wait = 0;
    start_session();
    wait_done(n);
    check("t1_addi1", ALUresult_out, 32'd5);
    wait_done(n);
    check("t1_gap2", n, 4);
    check("t1_addi2", ALUresult_out, 32'hFFFF_FFFD);
    wait_done(n);
    check("t1_gap3", n, 4);
    check("t1_add", ALUresult_out, 32'd2);
    fixed_wait = 2;
    wc0 = wr_count;
    wait_done(n);
    check("t2_sw_gap", n, 8);
    check("t2_sw_ir", instruction_out, img[3]);
    wait_done(n);
    check("t2_lw_gap", n, 9);
    check("t2_wr_addr", wr_addr, 32'h8);
    check("t2_wr_data", wr_data, 32'd2);
    check("t2_wr_count", wr_count - wc0, 1);
    wait_done(n);
    check("t2_lw_value", ALUresult_out, 32'd2);
    after_edge();
    check("t2_pc", pc_out, 32'h18);

    // Jumps, jal/jr link, and a taken beq back onto itself.
    clear_img();
    img[0]  = enc_j(2, 8);
    img[8]  = enc_j(3, 16);
    img[16] = enc_r(8, 31, 0, 0);
    img[9]  = enc_j(2, 4);
    img[4]  = enc_i(4, 0, 0, -1);
    fixed_wait = 0;
    start_session();
    for (int i = 0; i < 5; i++) begin
      wait_done(n);
      if (i > 0) check("t3_gap", n, 3);
      after_edge();
      check("t3_pc", pc_out, exp_pc[i]);
    end

    // Slave that never answers.
    clear_img();
    hang = 1'b1;
    start_session();
    req_cnt = int'(mem_req);
    n = 0;
    while (!fault && n < 100) begin
      @(negedge clock);
      n++;
      if (mem_req) req_cnt++;
    end
    check("t4_fault", {31'b0, fault}, 32'd1);
    check("t4_req_cycles", req_cnt, 16);
    check("t4_req_low", {31'b0, mem_req}, 32'd0);
    check("t4_state", {29'b0, state_out}, 32'd5);
    hang = 1'b0;
    repeat (5) @(negedge clock);
    check("t4_sticky", {31'b0, fault}, 32'd1);
    check("t4_req_after", {31'b0, mem_req}, 32'd0);

    // Misaligned lw: fault from EXEC, no data request.
    clear_img();
    img[0] = enc_i(8'h23, 0, 2, 6);
    start_session();
    req_cnt = int'(mem_req);
    repeat (8) begin
      @(negedge clock);
      if (mem_req) req_cnt++;
    end
    check("t5_lw_req", req_cnt, 1);
    check("t5_lw_fault", {31'b0, fault}, 32'd1);
    check("t5_lw_pc", pc_out, 32'h4);

    // Illegal opcode: fault directly out of DECODE.
    clear_img();
    img[0] = 32'hFC00_0000;
    start_session();
    n = 0;
    while (!fault && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("t5_ill_cycles", n, 2);
    check("t5_ill_ir", instruction_out, 32'hFC00_0000);
    check("t5_ill_pc", pc_out, 32'h4);

    // Reset in the middle of a three-wait-state fetch; $0 stays zero.
    clear_img();
    img[0] = enc_i(8, 0, 0, 7);
    img[1] = enc_r(32, 0, 0, 5);
    fixed_wait = 3;
    start_session();
    @(negedge clock);
    check("t6_req_before", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    check("t6_req_dropped", {31'b0, mem_req}, 32'd0);
    check("t6_pc", pc_out, 32'h0);
    check("t6_state", {29'b0, state_out}, 32'd0);
    @(negedge clock);
    fixed_wait = 0;
    reset = 1'b0;
    wait_done(n);
    check("t6_addi_alu", ALUresult_out, 32'd7);
    wait_done(n);
    check("t6_zero_reg", ALUresult_out, 32'd0);

    // Random program with random wait states, forward-only branches.
    for (int i = 0; i < 256; i++) img[i] = $urandom;
    for (int i = 0; i < 128; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: img[i] = enc_r(fn_tab[$urandom_range(0, 4)], $urandom_range(0, 7),
                                   $urandom_range(0, 7), $urandom_range(0, 7));
        4, 5, 6: img[i] = enc_i(iop_tab[$urandom_range(0, 2)], $urandom_range(0, 7),
                                $urandom_range(0, 7), $urandom_range(0, 65535));
        7: img[i] = enc_i(8'h23, 0, $urandom_range(0, 7), 32'h200 + 4 * $urandom_range(0, 127));
        8: img[i] = enc_i(8'h2b, 0, $urandom_range(0, 7), 32'h200 + 4 * $urandom_range(0, 127));
        default: img[i] = enc_i($urandom_range(4, 5), $urandom_range(0, 3),
                                $urandom_range(0, 3), $urandom_range(0, 2));
      endcase
    end
    for (int i = 0; i < 256; i++) mmem[i] = img[i];
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    mpc = 32'h0;
    rand_mode = 1'b1;
    start_session();
    for (int i = 0; i < 40; i++) begin
      model_step(e_ins, e_alu, e_av);
      wait_done(n);
      check("rnd_ir", instruction_out, e_ins);
      if (e_av) check("rnd_alu", ALUresult_out, e_alu);
      after_edge();
      check("rnd_pc", pc_out, mpc);
    end
    reset = 1'b1;
    @(negedge clock);
    for (int i = 128; i < 256; i++) check("rnd_dmem", mem[i], mmem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
